// File: rtl/hive_alu_logical_pipe_pkg.sv
// hive_alu_logical_pipe_pkg
// Shared types, default widths and generic bit helpers for the hive logic pipe.
//   lg_op_t     : logic operation encoding. lg_pop/lg_tzc are always reserved;
//                 they are only decoded when HIVE_LG_BITCNT_EN is defined.
//   HIVE_ALU_W  : default operand width.
//   HIVE_FLG_W  : flag vector width (decode uses bits 3:0).
//   Helpers work on an FN_W-wide container; only the low 'w' bits are
//   significant, so one function body serves every ALU_W up to FN_W.
package hive_alu_logical_pipe_pkg;

  localparam int HIVE_ALU_W = 32;
  localparam int HIVE_FLG_W = 4;
  localparam int FN_W       = 512;

  typedef enum logic [3:0] {
    lg_cpy = 4'd0,
    lg_nsb = 4'd1,
    lg_lim = 4'd2,
    lg_sat = 4'd3,
    lg_flp = 4'd4,
    lg_swp = 4'd5,
    lg_not = 4'd6,
    lg_and = 4'd7,
    lg_orr = 4'd8,
    lg_xor = 4'd9,
    lg_brx = 4'd10,
    lg_sgn = 4'd11,
    lg_lzc = 4'd12,
    lg_pop = 4'd13,
    lg_tzc = 4'd14
  } lg_op_t;

  // Bit reverse of the low w bits.
  function automatic logic [FN_W-1:0] flip(input logic [FN_W-1:0] v, input int w);
    logic [FN_W-1:0] r;
    r = '0;
    for (int i = 0; i < FN_W; i++)
      if (i < w) r[w-1-i] = v[i];
    return r;
  endfunction

  // Byte reverse of the low w bits (w is a multiple of 8).
  function automatic logic [FN_W-1:0] byte_swap(input logic [FN_W-1:0] v, input int w);
    logic [FN_W-1:0] r;
    r = '0;
    for (int i = 0; i < FN_W/8; i++)
      if (i < w/8) r[8*(w/8-1-i) +: 8] = v[8*i +: 8];
    return r;
  endfunction

  // Leading zero count of the low w bits; an all-zero value yields w.
  function automatic int lzc(input logic [FN_W-1:0] v, input int w);
    int r;
    r = w;
    for (int i = 0; i < FN_W; i++)
      if (i < w && v[i]) r = w - 1 - i;
    return r;
  endfunction

  // Trailing zero count of the low w bits; an all-zero value yields w.
  function automatic int tzc(input logic [FN_W-1:0] v, input int w);
    int r;
    r = w;
    for (int i = FN_W-1; i >= 0; i--)
      if (i < w && v[i]) r = i;
    return r;
  endfunction

  // Population count of the low w bits.
  function automatic int popcnt(input logic [FN_W-1:0] v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < FN_W; i++)
      if (i < w && v[i]) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/hive_alu_logical_pipe_ctrl.sv
// hive_alu_logical_pipe_ctrl
// Reusable valid chain plus stall/ready generation for a STAGES-deep
// whole-pipe-stall pipeline (STAGES >= 2).
//   clk, rst_n : clock, async active-low reset
//   up_valid   : upstream op valid
//   up_ready   : pipe can accept this cycle
//   dn_valid   : last stage holds a valid result
//   dn_ready   : downstream accepts the result
//   adv        : all stages load this cycle (data registers use it as enable)
//   stage_vld  : per-stage valid bits, [0] is the first stage
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high; valid never depends combinationally on ready, and an offered valid
// result is held unchanged until it transfers.
module hive_alu_logical_pipe_ctrl #(
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic              adv,
  output logic [STAGES-1:0] stage_vld
);

  logic stall;

  // Only a valid, unaccepted result freezes the pipe; bubbles keep flowing.
  assign stall    = stage_vld[STAGES-1] & ~dn_ready;
  assign adv      = ~stall;
  assign up_ready = ~stall;
  assign dn_valid = stage_vld[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= '0;
    end else if (adv) begin
      stage_vld <= {stage_vld[STAGES-2:0], up_valid};
    end
  end

endmodule

// File: rtl/hive_alu_logical_pipe.sv
// hive_alu_logical_pipe
// Three-stage (IN/MID/OUT) flow-controlled logic unit with sideband tag.
// Fixed latency of 3 accepted cycles; any stall freezes all stages.
//   clk_i, rst_n_i     : clock, async active-low reset
//   valid_i / ready_o  : input handshake
//   lg_op_i            : operation (lg_op_t)
//   tag_i, a_i, b_i    : tag and operands
//   b_flg_i            : flags of B (bits 3:0 decoded in IN)
//   valid_o / ready_i  : output handshake
//   result_o, flg_o, tag_o : result with B flags and tag aligned to it
// Build option: HIVE_LG_BITCNT_EN adds lg_pop and lg_tzc; without it those
// encodings return 0 like any undefined op and no count logic is built.
module hive_alu_logical_pipe
  import hive_alu_logical_pipe_pkg::*;
#(
  parameter int ALU_W = HIVE_ALU_W,
  parameter int FLG_W = HIVE_FLG_W,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  lg_op_t           lg_op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [FLG_W-1:0] b_flg_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [ALU_W-1:0] result_o,
  output logic [FLG_W-1:0] flg_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int LZC_W = $clog2(ALU_W) + 1;
  localparam logic [ALU_W-1:0] SAT_MAX = {1'b0, {(ALU_W-1){1'b1}}};
  localparam logic [ALU_W-1:0] SAT_MIN = {1'b1, {(ALU_W-1){1'b0}}};
  localparam logic [ALU_W-1:0] ONE     = {{(ALU_W-1){1'b0}}, 1'b1};

  logic       adv;
  logic [2:0] stage_vld;

  hive_alu_logical_pipe_ctrl #(.STAGES(3)) u_ctrl (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .up_valid  (valid_i),
    .up_ready  (ready_o),
    .dn_valid  (valid_o),
    .dn_ready  (ready_i),
    .adv       (adv),
    .stage_vld (stage_vld)
  );

  // IN stage: capture operands and decode the B flags.
  lg_op_t           op1;
  logic [ALU_W-1:0] a1, b1;
  logic [FLG_W-1:0] flg1;
  logic [TAG_W-1:0] tag1;
  logic             olm1, ulm1, ofl1, ufl1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op1 <= lg_cpy; a1 <= '0; b1 <= '0; flg1 <= '0; tag1 <= '0;
      olm1 <= 1'b0; ulm1 <= 1'b0; ofl1 <= 1'b0; ufl1 <= 1'b0;
    end else if (adv) begin
      op1  <= lg_op_i;
      a1   <= a_i;
      b1   <= b_i;
      flg1 <= b_flg_i;
      tag1 <= tag_i;
      olm1 <= ~b_flg_i[3] & b_flg_i[2];
      ulm1 <= b_flg_i[3];
      ofl1 <= ~b_flg_i[3] & (b_flg_i[2] | b_flg_i[0]);
      ufl1 <= b_flg_i[3] & ~(b_flg_i[1] & b_flg_i[0]);
    end
  end

  // MID stage: intermediate results from the generic helpers.
  logic [FN_W-1:0]  b_ext, flip_v, swap_v;
  logic [31:0]      lzc_v;
  logic [ALU_W-1:0] res_b_n, res_bb_n, res_ab_n;

  always_comb begin
    b_ext = '0;
    b_ext[ALU_W-1:0] = b1;
  end

  assign flip_v = flip(b_ext, ALU_W);
  assign swap_v = byte_swap(b_ext, ALU_W);
  assign lzc_v  = lzc(b_ext, ALU_W);

  always_comb begin
    res_b_n = b1;
    case (op1)
      lg_nsb:  res_b_n = {~b1[ALU_W-1], b1[ALU_W-2:0]};
      lg_lim:  res_b_n = olm1 ? '1 : (ulm1 ? '0 : b1);
      lg_sat:  res_b_n = ofl1 ? SAT_MAX : (ufl1 ? SAT_MIN : b1);
      default: res_b_n = b1;
    endcase
    case (op1)
      lg_flp:  res_bb_n = flip_v[ALU_W-1:0];
      lg_swp:  res_bb_n = swap_v[ALU_W-1:0];
      default: res_bb_n = ~b1;
    endcase
    case (op1)
      lg_orr:  res_ab_n = a1 | b1;
      lg_xor:  res_ab_n = a1 ^ b1;
      default: res_ab_n = a1 & b1;
    endcase
  end

  lg_op_t           op2;
  logic [ALU_W-1:0] res_b2, res_bb2, res_ab2;
  logic             brx2, neg2, bz2;
  logic [LZC_W-1:0] lzc2;
  logic [FLG_W-1:0] flg2;
  logic [TAG_W-1:0] tag2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op2 <= lg_cpy; res_b2 <= '0; res_bb2 <= '0; res_ab2 <= '0;
      brx2 <= 1'b0; neg2 <= 1'b0; bz2 <= 1'b0; lzc2 <= '0;
      flg2 <= '0; tag2 <= '0;
    end else if (adv) begin
      op2     <= op1;
      res_b2  <= res_b_n;
      res_bb2 <= res_bb_n;
      res_ab2 <= res_ab_n;
      brx2    <= ^b1;
      neg2    <= b1[ALU_W-1];
      bz2     <= (b1 == '0);
      lzc2    <= lzc_v[LZC_W-1:0];
      flg2    <= flg1;
      tag2    <= tag1;
    end
  end

`ifdef HIVE_LG_BITCNT_EN
  logic [31:0]      pop_v, tzc_v;
  logic [LZC_W-1:0] pop2, tzc2;

  assign pop_v = popcnt(b_ext, ALU_W);
  assign tzc_v = tzc(b_ext, ALU_W);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pop2 <= '0; tzc2 <= '0;
    end else if (adv) begin
      pop2 <= pop_v[LZC_W-1:0];
      tzc2 <= tzc_v[LZC_W-1:0];
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^{pop_v[31:LZC_W], tzc_v[31:LZC_W]};
`endif

  // OUT stage: final select. Unknown encodings give a clean 0.
  logic [ALU_W-1:0] out_n;

  always_comb begin
    out_n = '0;
    case (op2)
      lg_cpy, lg_nsb, lg_lim, lg_sat: out_n = res_b2;
      lg_flp, lg_swp, lg_not:         out_n = res_bb2;
      lg_and, lg_orr, lg_xor:         out_n = res_ab2;
      lg_brx:  out_n = brx2 ? '1 : '0;
      lg_sgn:  out_n = neg2 ? '1 : (bz2 ? '0 : ONE);
      lg_lzc:  out_n = {{(ALU_W-LZC_W){1'b0}}, lzc2};
`ifdef HIVE_LG_BITCNT_EN
      lg_pop:  out_n = {{(ALU_W-LZC_W){1'b0}}, pop2};
      lg_tzc:  out_n = {{(ALU_W-LZC_W){1'b0}}, tzc2};
`endif
      default: out_n = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_o <= '0; flg_o <= '0; tag_o <= '0;
    end else if (adv) begin
      result_o <= out_n;
      flg_o    <= flg2;
      tag_o    <= tag2;
    end
  end

  // Helper containers are wider than the datapath; the top bits are always 0.
  logic unused_bits;
  assign unused_bits = ^{flip_v[FN_W-1:ALU_W], swap_v[FN_W-1:ALU_W],
                         lzc_v[31:LZC_W], stage_vld};

endmodule

// File: tb/tb_hive_alu_logical_pipe.sv
module tb_hive_alu_logical_pipe;
  import hive_alu_logical_pipe_pkg::*;

  localparam int ALU_W = 32;
  localparam int FLG_W = 4;
  localparam int TAG_W = 4;
  localparam int W     = ALU_W + FLG_W + TAG_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n_i;
  always #5 clk = ~clk;

  logic             valid_i, ready_o, valid_o, ready_i;
  lg_op_t           lg_op_i;
  logic [TAG_W-1:0] tag_i, tag_o;
  logic [ALU_W-1:0] a_i, b_i, result_o;
  logic [FLG_W-1:0] b_flg_i, flg_o;

  hive_alu_logical_pipe #(.ALU_W(ALU_W), .FLG_W(FLG_W), .TAG_W(TAG_W)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .lg_op_i  (lg_op_i),
    .tag_i    (tag_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .b_flg_i  (b_flg_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .flg_o    (flg_o),
    .tag_o    (tag_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic issue(input lg_op_t op, input logic [ALU_W-1:0] a, input logic [ALU_W-1:0] b,
                       input logic [FLG_W-1:0] flg, input logic [TAG_W-1:0] tag,
                       input logic [ALU_W-1:0] res);
    int guard;
    @(negedge clk);
    valid_i = 1'b1; lg_op_i = op; a_i = a; b_i = b; b_flg_i = flg; tag_i = tag;
    exp_cur = {res, flg, tag};
    #1;
    guard = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!ready_o) check("issue_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk); #2;
      g++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // input monitor: record expected response of each accepted op
  always @(negedge clk) begin
    #1;
    if (rst_n_i && valid_i && ready_o) exp_q.push_back(exp_cur);
  end

  // output monitor / scoreboard
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out   = '0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    #1;
    if (!rst_n_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(valid_o), 64'd1);
        check("stall_hold_data", 64'({result_o, flg_o, tag_o}), 64'(prev_out));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'({result_o, flg_o, tag_o}), 64'd0 - 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", 64'({result_o, flg_o, tag_o}), 64'(e));
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_out   = {result_o, flg_o, tag_o};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [ALU_W-1:0] pop_exp, tzc_exp;

  initial begin
`ifdef HIVE_LG_BITCNT_EN
    pop_exp = 32'd12; tzc_exp = 32'd8;
`else
    pop_exp = 32'd0;  tzc_exp = 32'd0;
`endif
    rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; lg_op_i = lg_cpy;
    a_i = '0; b_i = '0; b_flg_i = '0; tag_i = '0; exp_cur = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid_o",  64'(valid_o),  64'd0);
    check("rst_result_o", 64'(result_o), 64'd0);
    check("rst_flg_o",    64'(flg_o),    64'd0);
    check("rst_tag_o",    64'(tag_o),    64'd0);
    check("rst_ready_o",  64'(ready_o),  64'd1);
    @(negedge clk);
    rst_n_i = 1'b1;

    // directed ops, no stall
    issue(lg_swp, 32'h0, 32'h11223344, 4'h0, 4'h1, 32'h44332211);
    issue(lg_flp, 32'h0, 32'h00000001, 4'h2, 4'h2, 32'h80000000);
    issue(lg_lzc, 32'h0, 32'h00000000, 4'h0, 4'h3, 32'd32);
    issue(lg_lzc, 32'h0, 32'h00010000, 4'h0, 4'h4, 32'd15);
    issue(lg_lzc, 32'h0, 32'h80000000, 4'h0, 4'h5, 32'd0);
    issue(lg_sat, 32'h0, 32'h12345678, 4'b0001, 4'h6, 32'h7FFFFFFF);
    issue(lg_sat, 32'h0, 32'h12345678, 4'b1000, 4'h7, 32'h80000000);
    issue(lg_sat, 32'h0, 32'h12345678, 4'b1011, 4'h8, 32'h12345678);
    issue(lg_lim, 32'h0, 32'h12345678, 4'b0100, 4'h9, 32'hFFFFFFFF);
    issue(lg_lim, 32'h0, 32'h12345678, 4'b1000, 4'hA, 32'h00000000);
    issue(lg_lim, 32'h0, 32'h12345678, 4'b0000, 4'hB, 32'h12345678);
    issue(lg_sgn, 32'h0, 32'hFFFFFFF0, 4'hC, 4'hC, 32'hFFFFFFFF);
    issue(lg_sgn, 32'h0, 32'h00000000, 4'h3, 4'hD, 32'h00000000);
    issue(lg_sgn, 32'h0, 32'h00000005, 4'h9, 4'hE, 32'h00000001);
    issue(lg_cpy, 32'h0, 32'hDEADBEEF, 4'h5, 4'hF, 32'hDEADBEEF);
    issue(lg_nsb, 32'h0, 32'h00000001, 4'h0, 4'h1, 32'h80000001);
    issue(lg_not, 32'h0, 32'h0F0F0F0F, 4'h0, 4'h2, 32'hF0F0F0F0);
    issue(lg_and, 32'hFF00FF00, 32'h0FF00FF0, 4'h0, 4'h3, 32'h0F000F00);
    issue(lg_orr, 32'hFF00FF00, 32'h0FF00FF0, 4'h0, 4'h4, 32'hFFF0FFF0);
    issue(lg_xor, 32'hFF00FF00, 32'h0FF00FF0, 4'h0, 4'h5, 32'hF0F0F0F0);
    issue(lg_brx, 32'h0, 32'h00000007, 4'h0, 4'h6, 32'hFFFFFFFF);
    issue(lg_brx, 32'h0, 32'h00000003, 4'h0, 4'h7, 32'h00000000);
    issue(lg_pop, 32'h0, 32'hF0F0000F, 4'h0, 4'h8, pop_exp);
    issue(lg_tzc, 32'h0, 32'h00000100, 4'h0, 4'h9, tzc_exp);
    issue(lg_op_t'(4'hF), 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h1, 4'hA, 32'h00000000);
    idle(1);
    drain();

    // backpressure: 5 back-to-back ops, downstream stalls for 6 cycles
    fork
      begin
        for (int t = 1; t <= 5; t++)
          issue(lg_cpy, 32'h0, 32'(t), 4'(t), 4'(t), 32'(t));
        idle(1);
      end
      begin
        repeat (4) @(negedge clk);
        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
          #1;
          check("bp_ready_low", 64'(ready_o), 64'd0);
          check("bp_valid_held", 64'(valid_o), 64'd1);
          @(negedge clk);
        end
        ready_i = 1'b1;
      end
    join
    drain();

    // reset with three ops in flight
    @(negedge clk);
    ready_i = 1'b0;
    issue(lg_cpy, 32'h0, 32'hAAAA0001, 4'h1, 4'h1, 32'hAAAA0001);
    issue(lg_cpy, 32'h0, 32'hAAAA0002, 4'h2, 4'h2, 32'hAAAA0002);
    issue(lg_cpy, 32'h0, 32'hAAAA0003, 4'h3, 4'h3, 32'hAAAA0003);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("inflight_valid_o", 64'(valid_o), 64'd1);
    @(posedge clk);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rst_async_valid_o", 64'(valid_o), 64'd0);
    exp_q.delete();
    @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    rst_n_i = 1'b1;
    #1;
    check("post_rst_ready_o", 64'(ready_o), 64'd1);
    check("post_rst_valid_o", 64'(valid_o), 64'd0);
    repeat (6) @(negedge clk);
    issue(lg_not, 32'h0, 32'h0000FFFF, 4'h6, 4'h6, 32'hFFFF0000);
    idle(1);
    drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
